// File: rtl/counter_pkg.sv
// Shared definitions for the counter observer.
//   state_e   : observer FSM states (IDLE, CHECK, FAIL)
//   CNT_WIDTH : default counter width
//   ERR_MAX   : saturation limit of the mismatch counter
//   WRAP_MAX  : saturation limit of the wrap-around counter
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FAIL  = 2'd2
  } state_e;

  localparam int CNT_WIDTH = 8;
  localparam int ERR_MAX   = 255;
  localparam int WRAP_MAX  = 65535;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : clock, rising edge
//   clr : synchronous clear, active-high, has priority over en
//   en  : count enable; holds at MAX once reached
//   q   : current count
module sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] LIMIT = W'(MAX);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == LIMIT) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clr)     q <= '0;
    else if (en) q <= sat_inc(q);
  end

endmodule

// File: rtl/counter_checker.sv
// Self-checking observer for the preloadable up-counter. Snoops the counter's
// reset/preload/pl_data and checks qout every cycle against a reference model.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset shared with the counter
//   preload    : snooped counter load strobe
//   pl_data    : snooped counter load value
//   qout       : counter output under check
//   err        : sticky mismatch flag
//   err_pulse  : one-cycle strobe per mismatch
//   err_count  : saturating mismatch count
//   wrap_count : saturating count of model wraps all-ones -> 0
//   first_exp  : expected value at the first mismatch
//   first_act  : observed value at the first mismatch
//   checking   : high while the FSM is in CHECK
module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH       = CNT_WIDTH,
  parameter bit RESYNC      = 1'b1,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preload,
  input  logic [WIDTH-1:0] pl_data,
  input  logic [WIDTH-1:0] qout,
  output logic             err,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [15:0]      wrap_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_act,
  output logic             checking
);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] exp_val;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] exp_nxt;
  logic             cmp_en;
  logic             mismatch;
  logic             wrap_inc;

  // The first cycle with reset low is still IDLE in the state register, but
  // qout must already be 0 there, so comparison runs in IDLE as well.
  always_comb begin
    cmp_en   = !reset && (state != FAIL);
    mismatch = cmp_en && (qout != exp_val);
    // On a resync the model continues from what the counter actually shows.
    base     = (mismatch && RESYNC) ? qout : exp_val;
    exp_nxt  = preload ? pl_data : base + WIDTH'(1);
    wrap_inc = cmp_en && !preload && (base == '1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (mismatch && STOP_ON_ERR) ? FAIL : CHECK;
      CHECK:   if (mismatch && STOP_ON_ERR) state_nxt = FAIL;
      FAIL:    state_nxt = FAIL;
      default: state_nxt = IDLE;
    endcase
    if (reset) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      exp_val   <= '0;
      err       <= 1'b0;
      err_pulse <= 1'b0;
      first_exp <= '0;
      first_act <= '0;
      checking  <= 1'b0;
    end else begin
      state     <= state_nxt;
      checking  <= (state_nxt == CHECK);
      err_pulse <= mismatch;
      if (cmp_en) exp_val <= exp_nxt;
      if (mismatch) begin
        err <= 1'b1;
        if (!err) begin
          first_exp <= exp_val;
          first_act <= qout;
        end
      end
    end
  end

  sat_counter #(.W(8), .MAX(ERR_MAX)) u_err_cnt (
    .clk (clk),
    .clr (reset),
    .en  (mismatch),
    .q   (err_count)
  );

  sat_counter #(.W(16), .MAX(WRAP_MAX)) u_wrap_cnt (
    .clk (clk),
    .clr (reset),
    .en  (wrap_inc),
    .q   (wrap_count)
  );

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: three instances (resync, free-run, stop-on-error)
// share one stimulus stream; a behavioural model predicts each instance's
// outputs, a scoreboard queue carries them to a monitor that compares after
// every clock edge, and a few directed checks cover the named scenarios.
module tb_counter_checker;

  typedef struct packed {
    logic [7:0]  exp;
    logic        frozen;
    logic        err;
    logic        pulse;
    logic [7:0]  errs;
    logic [15:0] wraps;
    logic [7:0]  fe;
    logic [7:0]  fa;
    logic        chk;
  } mdl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       preload = 1'b0;
  logic [7:0] pl_data = 8'd0;
  logic [7:0] qout = 8'd0;

  logic a_err, a_pulse, a_chk, b_err, b_pulse, b_chk, c_err, c_pulse, c_chk;
  logic [7:0]  a_ecnt, b_ecnt, c_ecnt, a_fe, a_fa, b_fe, b_fa, c_fe, c_fa;
  logic [15:0] a_wcnt, b_wcnt, c_wcnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  mdl_t ma = '0, mb = '0, mc = '0;
  mdl_t qa[$], qb[$], qc[$];
  logic [7:0] cnt = 8'd0;  // what a correct counter shows next cycle

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(8), .RESYNC(1'b1), .STOP_ON_ERR(1'b0)) dut_a (
    .clk(clk), .reset(reset), .preload(preload), .pl_data(pl_data), .qout(qout),
    .err(a_err), .err_pulse(a_pulse), .err_count(a_ecnt), .wrap_count(a_wcnt),
    .first_exp(a_fe), .first_act(a_fa), .checking(a_chk));

  counter_checker #(.WIDTH(8), .RESYNC(1'b0), .STOP_ON_ERR(1'b0)) dut_b (
    .clk(clk), .reset(reset), .preload(preload), .pl_data(pl_data), .qout(qout),
    .err(b_err), .err_pulse(b_pulse), .err_count(b_ecnt), .wrap_count(b_wcnt),
    .first_exp(b_fe), .first_act(b_fa), .checking(b_chk));

  counter_checker #(.WIDTH(8), .RESYNC(1'b1), .STOP_ON_ERR(1'b1)) dut_c (
    .clk(clk), .reset(reset), .preload(preload), .pl_data(pl_data), .qout(qout),
    .err(c_err), .err_pulse(c_pulse), .err_count(c_ecnt), .wrap_count(c_wcnt),
    .first_exp(c_fe), .first_act(c_fa), .checking(c_chk));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Outcome of one clock edge, straight from the counter contract.
  function automatic mdl_t model_step(input mdl_t m, input bit rs, input bit st,
                                      input logic rst, input logic pl,
                                      input logic [7:0] pd, input logic [7:0] q);
    mdl_t n;
    int   base;
    n = m;
    if (rst) return '0;
    if (m.frozen) begin
      n.pulse = 1'b0;
      return n;
    end
    n.pulse = (q != m.exp);
    if (n.pulse) begin
      if (!m.err) begin
        n.fe = m.exp;
        n.fa = q;
      end
      n.err = 1'b1;
      if (m.errs < 8'd255) n.errs = 8'(m.errs + 8'd1);
    end
    base = (n.pulse && rs) ? int'(q) : int'(m.exp);
    if (pl) n.exp = pd;
    else begin
      n.exp = 8'((base + 1) % 256);
      if (base == 255 && m.wraps < 16'hFFFF) n.wraps = 16'(m.wraps + 16'd1);
    end
    n.frozen = n.pulse && st;
    n.chk    = !n.frozen;
    return n;
  endfunction

  task automatic step(input logic rst, input logic pl, input logic [7:0] pd,
                      input logic [7:0] q);
    @(negedge clk);
    reset = rst; preload = pl; pl_data = pd; qout = q;
    ma = model_step(ma, 1'b1, 1'b0, rst, pl, pd, q);
    mb = model_step(mb, 1'b0, 1'b0, rst, pl, pd, q);
    mc = model_step(mc, 1'b1, 1'b1, rst, pl, pd, q);
    qa.push_back(ma); qb.push_back(mb); qc.push_back(mc);
    cnt = rst ? 8'd0 : (pl ? pd : 8'(q + 8'd1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, cnt);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic cmp_obs(input string t, input mdl_t e, input logic er, input logic pu,
                         input logic [7:0] ec, input logic [15:0] wc,
                         input logic [7:0] fe, input logic [7:0] fa, input logic ck);
    chk({t, ".err"}, 32'(er), 32'(e.err));
    chk({t, ".err_pulse"}, 32'(pu), 32'(e.pulse));
    chk({t, ".err_count"}, 32'(ec), 32'(e.errs));
    chk({t, ".wrap_count"}, 32'(wc), 32'(e.wraps));
    chk({t, ".first_exp"}, 32'(fe), 32'(e.fe));
    chk({t, ".first_act"}, 32'(fa), 32'(e.fa));
    chk({t, ".checking"}, 32'(ck), 32'(e.chk));
  endtask

  mdl_t ea, eb, ec;
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
      cmp_obs("a", ea, a_err, a_pulse, a_ecnt, a_wcnt, a_fe, a_fa, a_chk);
      cmp_obs("b", eb, b_err, b_pulse, b_ecnt, b_wcnt, b_fe, b_fa, b_chk);
      cmp_obs("c", ec, c_err, c_pulse, c_ecnt, c_wcnt, c_fe, c_fa, c_chk);
    end
  end

  int r;
  initial begin
    // Reset, then free-run against a correct counter.
    repeat (3) step(1'b1, 1'b0, 8'd0, 8'd0);
    step(1'b0, 1'b0, 8'd0, cnt);
    settle();
    chk("checking_first_cycle", 32'(a_chk), 32'd1);
    run(29);
    settle();
    chk("freerun_err", 32'(a_err), 32'd0);
    chk("freerun_err_count", 32'(a_ecnt), 32'd0);
    chk("freerun_wrap_count", 32'(a_wcnt), 32'd0);

    // Single preload pulse to 50.
    step(1'b0, 1'b1, 8'd50, cnt);
    run(30);
    settle();
    chk("preload50_err", 32'(a_err), 32'd0);
    chk("preload50_stop_err", 32'(c_err), 32'd0);

    // Wrap counting, preload to all-ones, preload to zero.
    step(1'b1, 1'b0, 8'd0, 8'd0);
    run(300);
    settle();
    chk("wrap_once", 32'(a_wcnt), 32'd1);
    chk("wrap_once_err", 32'(a_err), 32'd0);
    step(1'b0, 1'b1, 8'd255, cnt);
    run(2);
    settle();
    chk("wrap_after_pl255", 32'(a_wcnt), 32'd2);
    step(1'b0, 1'b1, 8'd0, cnt);
    run(2);
    settle();
    chk("wrap_after_pl0", 32'(a_wcnt), 32'd2);

    // Counter jumps to 7 where 5 is expected.
    step(1'b1, 1'b0, 8'd0, 8'd0);
    run(5);
    step(1'b0, 1'b0, 8'd0, 8'd7);
    settle();
    chk("inject_pulse", 32'(a_pulse), 32'd1);
    chk("inject_first_exp", 32'(a_fe), 32'd5);
    chk("inject_first_act", 32'(a_fa), 32'd7);
    chk("inject_err_count", 32'(a_ecnt), 32'd1);
    run(5);
    settle();
    chk("resync_no_more_errs", 32'(a_ecnt), 32'd1);
    chk("resync_pulse_low", 32'(a_pulse), 32'd0);
    chk("freerun_errs_each_cycle", 32'(b_ecnt), 32'd6);
    chk("stop_checking_low", 32'(c_chk), 32'd0);
    chk("stop_err_count_frozen", 32'(c_ecnt), 32'd1);
    chk("stop_pulse_low", 32'(c_pulse), 32'd0);
    step(1'b1, 1'b0, 8'd0, cnt);
    settle();
    chk("stop_reset_err", 32'(c_err), 32'd0);
    chk("stop_reset_err_count", 32'(c_ecnt), 32'd0);
    chk("stop_reset_first_exp", 32'(c_fe), 32'd0);
    chk("stop_reset_first_act", 32'(c_fa), 32'd0);
    step(1'b0, 1'b0, 8'd0, cnt);
    settle();
    chk("stop_checking_resumes", 32'(c_chk), 32'd1);

    // Continuous garbage on qout: error counter saturation.
    step(1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 8'd0, 8'($urandom_range(0, 255)));
    settle();
    chk("err_count_saturates", 32'(b_ecnt), 32'd255);
    // Reset beats a simultaneous preload.
    step(1'b1, 1'b1, 8'd99, cnt);
    step(1'b0, 1'b0, 8'd0, cnt);
    settle();
    chk("reset_beats_preload_pulse", 32'(a_pulse), 32'd0);
    chk("reset_beats_preload_err", 32'(a_err), 32'd0);

    // Randomised mix of preloads, glitches and resets.
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 63));
      if (r == 0)     step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), cnt);
      else if (r < 6) step(1'b0, 1'b1, 8'($urandom_range(0, 255)), cnt);
      else if (r < 8) step(1'b0, 1'b0, 8'd0, 8'($urandom_range(0, 255)));
      else            step(1'b0, 1'b0, 8'd0, cnt);
    end
    settle();
    chk("scoreboard_drained", 32'(qa.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
